uart_tx_fifo: RTL and testbench

//  Buffered UART transmitter (8N1, LSB first), host-side writer for the serial line that uart_rx receives.

---
 rtl/uart_tx_fifo.sv | 208 ++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered 8N1 UART transmitter, LSB first.
// Define UART_TX_PARITY_EN to add an even-parity bit before stop.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 87,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                        i_Clock,
    input  logic                        i_Rst_n,
    input  logic                        i_Tx_DV,
    input  logic [7:0]                  i_Tx_Byte,
    output logic                        o_Fifo_Full,
    output logic                        o_Fifo_Empty,
    output logic [$clog2(FIFO_DEPTH):0] o_Fifo_Count,
    output logic                        o_Overflow,
    output logic                        o_Tx_Active,
    output logic                        o_Tx_Serial,
    output logic                        o_Tx_Done
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_nxt;
    logic          push;
    logic          pop;

    state_t        state;
    state_t        state_nxt;
    logic [15:0]   timer;
    logic [2:0]    bit_idx;
    logic [7:0]    tx_byte;
    logic          bit_end;

    logic          line_d;
    logic          done_d;
    logic          active_d;

    // Writes are gated by the registered full flag only, so a pop on
    // the same edge cannot rescue a write attempted while full.
    assign push    = i_Tx_DV && !o_Fifo_Full;
    assign bit_end = (timer == BIT_LAST);

    // Next occupancy from this edge's push/pop pair
    always_comb begin
        count_nxt = o_Fifo_Count;
        unique case ({push, pop})
            2'b10:   count_nxt = o_Fifo_Count + CW'(1);
            2'b01:   count_nxt = o_Fifo_Count - CW'(1);
            default: count_nxt = o_Fifo_Count;
        endcase
    end

    // Byte storage; contents are don't-care until written
    always_ff @(posedge i_Clock) begin
        if (push) begin
            mem[wr_ptr] <= i_Tx_Byte;
        end
    end

    // Pointers, occupancy and registered status flags
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            o_Fifo_Count <= '0;
            o_Fifo_Full  <= 1'b0;
            o_Fifo_Empty <= 1'b1;
            o_Overflow   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            o_Fifo_Count <= count_nxt;
            o_Fifo_Full  <= (count_nxt == CNT_FULL);
            o_Fifo_Empty <= (count_nxt == '0);
            o_Overflow   <= i_Tx_DV && o_Fifo_Full;
        end
    end

    // Serializer state register
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state; pops happen on leaving IDLE or the last stop clock
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (!o_Fifo_Empty) begin
                    pop       = 1'b1;
                    state_nxt = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end && bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                    state_nxt = S_PARITY;
`else
                    state_nxt = S_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    state_nxt = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    if (!o_Fifo_Empty) begin
                        pop       = 1'b1;
                        state_nxt = S_START;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Bit timer, data bit index and the shift-register copy of the head
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            timer   <= '0;
            bit_idx <= '0;
            tx_byte <= '0;
        end else begin
            if (pop) begin
                tx_byte <= mem[rd_ptr];
            end
            if (state == S_IDLE || bit_end) begin
                timer <= '0;
            end else begin
                timer <= timer + 16'd1;
            end
            if (state != S_DATA) begin
                bit_idx <= '0;
            end else if (bit_end) begin
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end

    // Line level and status decoded from the current state
    always_comb begin
        line_d   = 1'b1;
        done_d   = 1'b0;
        active_d = (state != S_IDLE);
        unique case (state)
            S_START: line_d = 1'b0;
            S_DATA:  line_d = tx_byte[bit_idx];
`ifdef UART_TX_PARITY_EN
            S_PARITY: line_d = ^tx_byte;
`endif
            S_STOP: begin
                line_d = 1'b1;
                done_d = bit_end;
            end
            default: line_d = 1'b1;
        endcase
    end

    // Registered pad outputs; reset forces the line idle at once
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            o_Tx_Serial <= 1'b1;
            o_Tx_Done   <= 1'b0;
            o_Tx_Active <= 1'b0;
        end else begin
            o_Tx_Serial <= line_d;
            o_Tx_Done   <= done_d;
            o_Tx_Active <= active_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed + random bench for uart_tx_fifo.
// Queue model of FIFO/frame schedule plus a line decoder.
module tb_uart_tx_fifo;

    localparam int C = 25;
    localparam int D = 16;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = NB * C;

    logic       i_Clock;
    logic       i_Rst_n;
    logic       i_Tx_DV;
    logic [7:0] i_Tx_Byte;
    logic       o_Fifo_Full;
    logic       o_Fifo_Empty;
    logic [4:0] o_Fifo_Count;
    logic       o_Overflow;
    logic       o_Tx_Active;
    logic       o_Tx_Serial;
    logic       o_Tx_Done;

    uart_tx_fifo #(
        .CLKS_PER_BIT(C),
        .FIFO_DEPTH  (D)
    ) dut (
        .i_Clock     (i_Clock),
        .i_Rst_n     (i_Rst_n),
        .i_Tx_DV     (i_Tx_DV),
        .i_Tx_Byte   (i_Tx_Byte),
        .o_Fifo_Full (o_Fifo_Full),
        .o_Fifo_Empty(o_Fifo_Empty),
        .o_Fifo_Count(o_Fifo_Count),
        .o_Overflow  (o_Overflow),
        .o_Tx_Active (o_Tx_Active),
        .o_Tx_Serial (o_Tx_Serial),
        .o_Tx_Done   (o_Tx_Done)
    );

    initial i_Clock = 1'b0;
    always #5 i_Clock = ~i_Clock;

    typedef struct {
        logic [7:0] data;
        logic       start_ok;
        logic       stop_ok;
        logic       done_ok;
        logic       par;
        int         t0;
    } frame_t;

    frame_t rx_q[$];
    int     done_cnt = 0;
    int     cyc = 0;
    bit     m_on = 0;
    int     mt = 0;
    frame_t mrec;

    // Line decoder: samples mid-bit, logs one record per full frame
    initial begin
        forever begin
            @(negedge i_Clock);
            cyc++;
            if (!i_Rst_n) begin
                m_on = 0;
            end else if (!m_on) begin
                if (o_Tx_Serial === 1'b0) begin
                    m_on          = 1;
                    mt            = 0;
                    mrec.data     = 8'h00;
                    mrec.start_ok = 1'b0;
                    mrec.stop_ok  = 1'b0;
                    mrec.done_ok  = 1'b0;
                    mrec.par      = 1'b0;
                    mrec.t0       = cyc;
                end
            end else begin
                mt++;
            end
            if (m_on) begin
                if (mt == C / 2)
                    mrec.start_ok = (o_Tx_Serial === 1'b0);
                for (int k = 0; k < 8; k++)
                    if (mt == (k + 1) * C + C / 2)
                        mrec.data[k] = o_Tx_Serial;
`ifdef UART_TX_PARITY_EN
                if (mt == 9 * C + C / 2)
                    mrec.par = o_Tx_Serial;
`endif
                if (mt == (NB - 1) * C + C / 2)
                    mrec.stop_ok = (o_Tx_Serial === 1'b1);
                if (mt == NB * C - 1) begin
                    mrec.done_ok = (o_Tx_Done === 1'b1);
                    rx_q.push_back(mrec);
                    m_on = 0;
                end
            end
            if (i_Rst_n && o_Tx_Done === 1'b1)
                done_cnt++;
        end
    end

    int         n_vec = 0;
    int         n_err = 0;
    int         rx_rd = 0;
    logic [7:0] mq[$];
    logic [7:0] exp_q[$];
    bit         m_busy = 0;
    int         m_left = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, update model at posedge, check
    task automatic tick(input logic dv, input logic [7:0] b);
        int sz;
        bit busy_pre, endf, pop, ok;
        i_Tx_DV   = dv;
        i_Tx_Byte = b;
        @(posedge i_Clock);
        sz       = mq.size();
        busy_pre = m_busy;
        endf     = m_busy && (m_left == 1);
        pop      = (sz > 0) && (!m_busy || endf);
        ok       = dv && (sz < D);
        if (pop) void'(mq.pop_front());
        if (ok) begin
            mq.push_back(b);
            exp_q.push_back(b);
        end
        if (pop) begin
            m_busy = 1;
            m_left = FRAME;
        end else if (endf) begin
            m_busy = 0;
        end else if (m_busy) begin
            m_left--;
        end
        @(negedge i_Clock);
        chk("count", o_Fifo_Count, mq.size());
        chk("empty", o_Fifo_Empty, mq.size() == 0);
        chk("full", o_Fifo_Full, mq.size() == D);
        chk("ovf", o_Overflow, dv && !ok);
        chk("done", o_Tx_Done, endf);
        chk("active", o_Tx_Active, busy_pre);
    endtask

    task automatic drain();
        for (int i = 0; i < 40000 && (m_busy || mq.size() > 0); i++)
            tick(1'b0, 8'h00);
        repeat (3) tick(1'b0, 8'h00);
    endtask

    task automatic check_rx();
        frame_t     r;
        logic [7:0] eb;
        while (rx_rd < rx_q.size()) begin
            r = rx_q[rx_rd];
            rx_rd++;
            if (exp_q.size() == 0) begin
                chk("extra_frame", exp_q.size(), 1);
            end else begin
                eb = exp_q.pop_front();
                chk("rx_data", r.data, eb);
                chk("rx_start", r.start_ok, 1'b1);
                chk("rx_stop", r.stop_ok, 1'b1);
                chk("rx_done", r.done_ok, 1'b1);
`ifdef UART_TX_PARITY_EN
                chk("rx_parity", r.par, ^eb);
`endif
            end
        end
        chk("exp_left", exp_q.size(), 0);
        chk("done_cnt", done_cnt, rx_q.size());
    endtask

    initial begin
        int         n;
        int         rx_before;
        int         done_before;
        logic [7:0] ab;

        i_Rst_n   = 1'b0;
        i_Tx_DV   = 1'b0;
        i_Tx_Byte = 8'h00;
        repeat (3) @(negedge i_Clock);
        chk("rst_serial", o_Tx_Serial, 1'b1);
        chk("rst_empty", o_Fifo_Empty, 1'b1);
        chk("rst_full", o_Fifo_Full, 1'b0);
        chk("rst_count", o_Fifo_Count, 0);
        chk("rst_ovf", o_Overflow, 1'b0);
        chk("rst_active", o_Tx_Active, 1'b0);
        chk("rst_done", o_Tx_Done, 1'b0);
        i_Rst_n = 1'b1;
        repeat (2) tick(1'b0, 8'h00);

        // single byte: start bit two clocks after sampling edge
        tick(1'b1, 8'hAB);
        chk("lat_clk0", o_Tx_Serial, 1'b1);
        tick(1'b0, 8'h00);
        chk("lat_clk1", o_Tx_Serial, 1'b1);
        tick(1'b0, 8'h00);
        chk("lat_clk2", o_Tx_Serial, 1'b0);
        drain();
        check_rx();

        // three back-to-back frames, count peaks at 2
        tick(1'b1, 8'h2C);
        tick(1'b1, 8'h55);
        tick(1'b1, 8'hFF);
        chk("peak_count", o_Fifo_Count, 2);
        drain();
        check_rx();
        n = rx_q.size();
        chk("gap1", rx_q[n-2].t0 - rx_q[n-3].t0, FRAME);
        chk("gap2", rx_q[n-1].t0 - rx_q[n-2].t0, FRAME);

        // 17 pushes from idle: first pops, FIFO then full
        for (int i = 0; i < 17; i++)
            tick(1'b1, 8'($urandom));
        chk("fill_full", o_Fifo_Full, 1'b1);
        chk("fill_count", o_Fifo_Count, 16);
        chk("fill_ovf", o_Overflow, 1'b0);

        // push on the same edge as the end-of-frame pop while full
        for (int i = 0; i < FRAME + 5 && !(m_busy && m_left == 1); i++)
            tick(1'b0, 8'h00);
        tick(1'b1, 8'h5A);
        chk("pp_count", o_Fifo_Count, 15);
        chk("pp_ovf", o_Overflow, 1'b1);
        tick(1'b1, 8'h33);
        tick(1'b1, 8'h44);
        chk("full_drop_ovf", o_Overflow, 1'b1);
        drain();
        check_rx();

        // parity-sensitive pair
        tick(1'b1, 8'h07);
        tick(1'b1, 8'h03);
        drain();
        check_rx();

        // reset in the middle of bit 1 of 0xA5 with 4 bytes queued
        ab = 8'hA5;
        tick(1'b1, ab);
        for (int i = 0; i < 4; i++)
            tick(1'b1, 8'($urandom));
        for (int i = 0; i < 2 + 2 * C + C / 2 - 4; i++)
            tick(1'b0, 8'h00);
        chk("pre_rst_bit1", o_Tx_Serial, ab[1]);
        rx_before   = rx_q.size();
        done_before = done_cnt;
        #2;
        i_Rst_n = 1'b0;
        #1;
        chk("async_serial", o_Tx_Serial, 1'b1);
        chk("async_count", o_Fifo_Count, 0);
        mq.delete();
        exp_q.delete();
        m_busy = 0;
        repeat (2) @(negedge i_Clock);
        i_Rst_n = 1'b1;
        for (int i = 0; i < 2 * FRAME; i++)
            tick(1'b0, 8'h00);
        chk("post_rst_frames", rx_q.size(), rx_before);
        chk("post_rst_done", done_cnt, done_before);
        chk("post_rst_line", o_Tx_Serial, 1'b1);

        // random pushes, overflow included
        for (int i = 0; i < 1500; i++)
            tick($urandom_range(0, 29) == 0, 8'($urandom));
        drain();
        check_rx();

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
